// File: rtl/la_dump_pkg.sv
// la_dump_pkg
// Shared definitions for the logic-analyzer sample-dump controller:
// the sequencer state encoding, the header sync byte and the
// bytes-per-sample derivation.
// Optional feature macro used by the sequencer: LA_DUMP_HEADER_EN.
package la_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SEND,
        DONE
    } dump_state_e;

    localparam logic [7:0] DUMP_SYNC = 8'hA5;

    // Number of header bytes (sync, count high, count low).
    localparam int HDR_BYTES = 3;

    // Bytes per sample.  SAMPLE_W is expected to be a multiple of 8.
    function automatic int bytes_per_sample(input int sample_w);
        return sample_w / 8;
    endfunction

endpackage

// File: rtl/la_dump_if.sv
// la_dump_if
// Read port of the capture sample memory.
//   mem_rd   : read enable (sequencer -> memory)
//   mem_addr : read address (sequencer -> memory)
//   mem_data : read data, valid the cycle after mem_rd (memory -> sequencer)
// Modports: master (sequencer side), slave (memory side).
interface la_dump_if #(
    parameter int ADDR_W   = 10,
    parameter int SAMPLE_W = 16
);
    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic [SAMPLE_W-1:0] mem_data;

    modport master (output mem_rd, output mem_addr, input mem_data);
    modport slave  (input mem_rd, input mem_addr, output mem_data);
endinterface

// File: rtl/la_byte_serializer.sv
// la_byte_serializer
// Holds one sample word and presents it a byte at a time, most
// significant byte first.
//   clk, reset : clock, synchronous active-high reset
//   load       : capture load_data and restart at byte 0
//   load_data  : sample word to serialize
//   advance    : move on to the next byte
//   byte_out   : byte currently presented
//   last       : byte_out is the final byte of the word
module la_byte_serializer
    import la_dump_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [SAMPLE_W-1:0] load_data,
    input  logic                advance,
    output logic [7:0]          byte_out,
    output logic                last
);
    localparam int NB    = bytes_per_sample(SAMPLE_W);
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (load) begin
            shift_d = load_data;
            idx_d   = '0;
        end else if (advance) begin
            shift_d = shift_q << 8;
            idx_d   = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    assign byte_out = shift_q[SAMPLE_W-1 -: 8];
    assign last     = (idx_q == IDX_W'(NB - 1));

endmodule

// File: rtl/la_dump_sequencer.sv
// la_dump_sequencer
// Walks the capture memory from base_addr for count samples and streams
// each sample, MS byte first, into the UART TX FIFO, honouring the FIFO
// full flag.  Processor byte writes share the FIFO and always win.
//   clk, reset        : clock, synchronous active-high reset
//   start, abort      : begin / terminate a dump
//   base_addr, count  : dump window, sampled on start
//   busy, done        : dump in progress / one-cycle completion pulse
//   mem               : capture memory read port (la_dump_if.master)
//   cpu_tx_wr/_data   : processor byte write
//   utx_buffer_full   : UART TX FIFO full
//   utx_buffer_write  : UART TX FIFO write strobe
//   data_tx           : UART TX FIFO write data
// Build option: define LA_DUMP_HEADER_EN to prefix each dump with
// DUMP_SYNC, count[15:8], count[7:0].
module la_dump_sequencer
    import la_dump_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int SAMPLE_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    la_dump_if.master         mem,
    input  logic              cpu_tx_wr,
    input  logic [7:0]        cpu_tx_data,
    input  logic              utx_buffer_full,
    output logic              utx_buffer_write,
    output logic [7:0]        data_tx
);
    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
`ifdef LA_DUMP_HEADER_EN
    logic              hdr_active_q, hdr_active_d;
    logic [1:0]        hdr_idx_q, hdr_idx_d;
    logic [15:0]       count16;
    logic [7:0]        hdr_byte;
`endif

    logic       grant;
    logic       dump_wr;
    logic [7:0] dump_byte;
    logic       ser_load;
    logic       ser_advance;
    logic [7:0] ser_byte;
    logic       ser_last;

    la_byte_serializer #(.SAMPLE_W(SAMPLE_W)) u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (ser_load),
        .load_data(mem.mem_data),
        .advance  (ser_advance),
        .byte_out (ser_byte),
        .last     (ser_last)
    );

    // A dump byte may only go out when the FIFO has room and the
    // processor is not using the write port this cycle.
    assign grant = !utx_buffer_full && !cpu_tx_wr;

`ifdef LA_DUMP_HEADER_EN
    // remaining_q still holds the full count while the header is sent.
    assign count16 = 16'(remaining_q);
    always_comb begin
        case (hdr_idx_q)
            2'd0:    hdr_byte = DUMP_SYNC;
            2'd1:    hdr_byte = count16[15:8];
            default: hdr_byte = count16[7:0];
        endcase
    end
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        ser_load    = 1'b0;
        ser_advance = 1'b0;
        dump_wr     = 1'b0;
        dump_byte   = ser_byte;
`ifdef LA_DUMP_HEADER_EN
        hdr_active_d = hdr_active_q;
        hdr_idx_d    = hdr_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef LA_DUMP_HEADER_EN
                    // The header is sent even for a zero count.
                    addr_d       = base_addr;
                    remaining_d  = count;
                    hdr_active_d = 1'b1;
                    hdr_idx_d    = 2'd0;
                    state_d      = SEND;
`else
                    if (count != '0) begin
                        addr_d      = base_addr;
                        remaining_d = count;
                        state_d     = FETCH;
                    end else begin
                        state_d = DONE;
                    end
`endif
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                ser_load = 1'b1;
                state_d  = SEND;
            end
            SEND: begin
                dump_wr = grant;
`ifdef LA_DUMP_HEADER_EN
                if (hdr_active_q) begin
                    dump_byte = hdr_byte;
                    if (grant) begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                        if (hdr_idx_q == 2'(HDR_BYTES - 1)) begin
                            hdr_active_d = 1'b0;
                            state_d = (remaining_q == '0) ? DONE : FETCH;
                        end
                    end
                end else
`endif
                if (grant) begin
                    ser_advance = 1'b1;
                    if (ser_last) begin
                        addr_d      = addr_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        state_d = (remaining_q == (ADDR_W+1)'(1)) ? DONE : FETCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides everything, including a simultaneous start.
        if (abort) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
`ifdef LA_DUMP_HEADER_EN
            hdr_active_q <= 1'b0;
            hdr_idx_q    <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
`ifdef LA_DUMP_HEADER_EN
            hdr_active_q <= hdr_active_d;
            hdr_idx_q    <= hdr_idx_d;
`endif
        end
    end

    assign mem.mem_rd   = (state_q == FETCH);
    assign mem.mem_addr = addr_q;
    assign busy = (state_q == FETCH) || (state_q == WAIT) || (state_q == SEND);
    assign done = (state_q == DONE);

    // Processor path is purely combinational so it works even in reset.
    assign utx_buffer_write = cpu_tx_wr | dump_wr;
    assign data_tx          = cpu_tx_wr ? cpu_tx_data : dump_byte;

endmodule

// File: tb/tb_la_dump_sequencer.sv
// tb_la_dump_sequencer
// Directed bench for la_dump_sequencer: drives start/abort/full/processor
// writes on a per-cycle schedule, models the capture memory and logs every
// FIFO write, read address and done pulse relative to the start cycle.
// Expectations shift by three cycles when LA_DUMP_HEADER_EN is defined.
module tb_la_dump_sequencer;
    import la_dump_pkg::*;

    localparam int ADDR_W   = 10;
    localparam int SAMPLE_W = 16;
`ifdef LA_DUMP_HEADER_EN
    localparam int HDR = 3;
`else
    localparam int HDR = 0;
`endif

    logic              clk;
    logic              reset;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              cpu_tx_wr;
    logic [7:0]        cpu_tx_data;
    logic              utx_buffer_full;
    logic              utx_buffer_write;
    logic [7:0]        data_tx;

    la_dump_if #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) mem_bus ();

    la_dump_sequencer #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .base_addr       (base_addr),
        .count           (count),
        .busy            (busy),
        .done            (done),
        .mem             (mem_bus),
        .cpu_tx_wr       (cpu_tx_wr),
        .cpu_tx_data     (cpu_tx_data),
        .utx_buffer_full (utx_buffer_full),
        .utx_buffer_write(utx_buffer_write),
        .data_tx         (data_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture memory model: registered read, data valid the cycle after mem_rd.
    logic [SAMPLE_W-1:0] mem_model [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_bus.mem_rd) mem_bus.mem_data <= mem_model[mem_bus.mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Activity log, cycle numbers relative to the start cycle.
    bit capturing = 1'b0;
    int t0 = 0;
    int wr_b[$];
    int wr_c[$];
    int done_c[$];
    int rd_a[$];
    int rd_c[$];
    int busy_h[$];

    always @(negedge clk) begin
        if (capturing) begin
            if (utx_buffer_write) begin
                wr_b.push_back(int'(data_tx));
                wr_c.push_back(cyc - t0);
            end
            if (done) done_c.push_back(cyc - t0);
            if (mem_bus.mem_rd) begin
                rd_a.push_back(int'(mem_bus.mem_addr));
                rd_c.push_back(cyc - t0);
            end
            busy_h.push_back(int'(busy));
        end
    end

    // Per-test schedule of side inputs, in cycles relative to start.
    int full_lo  = -1;
    int full_hi  = -1;
    int cpu_at   = -1;
    int abort_at = -1;
    logic [7:0] cpu_byte = 8'h00;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic startExp(input logic [ADDR_W:0] n);
        exp_q.delete();
        if (HDR != 0) begin
            exp_q.push_back(int'(DUMP_SYNC));
            exp_q.push_back(int'({5'b0, n[10:8]}));
            exp_q.push_back(int'(n[7:0]));
        end
    endtask

    task automatic checkBytes(input string tag);
        checkOutput({tag, "_nbytes"}, 32'(wr_b.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i), 32'(qget(wr_b, i)), 32'(exp_q[i]));
        end
    endtask

    // Pulses start and runs ncyc cycles following the side-input schedule.
    task automatic applyStimulus(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n, input int ncyc);
        wr_b.delete(); wr_c.delete(); done_c.delete();
        rd_a.delete(); rd_c.delete(); busy_h.delete();
        t0 = cyc;
        capturing = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            start           = (i == 0);
            base_addr       = b;
            count           = n;
            utx_buffer_full = (i >= full_lo) && (i <= full_hi);
            cpu_tx_wr       = (i == cpu_at);
            cpu_tx_data     = cpu_byte;
            abort           = (i == abort_at);
            @(posedge clk); #1;
        end
        capturing = 1'b0;
        start = 1'b0; abort = 1'b0; cpu_tx_wr = 1'b0; utx_buffer_full = 1'b0;
        full_lo = -1; full_hi = -1; cpu_at = -1; abort_at = -1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; count = '0;
        cpu_tx_wr = 1'b1; cpu_tx_data = 8'h3C; utx_buffer_full = 1'b0;
        mem_model[10'h000] = 16'h1234;
        mem_model[10'h001] = 16'hABCD;
        mem_model[10'h002] = 16'h5AA5;
        mem_model[10'h3FF] = 16'h0F1E;

        // Reset values and processor pass-through while in reset.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_mem_rd", 32'(mem_bus.mem_rd), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_bus.mem_addr), 32'd0);
        checkOutput("rst_cpu_wr", 32'(utx_buffer_write), 32'd1);
        checkOutput("rst_cpu_data", 32'(data_tx), 32'h3C);
        cpu_tx_wr = 1'b0;
        #1;
        checkOutput("rst_no_wr", 32'(utx_buffer_write), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic dump of two samples.
        $display("[TB] basic dump");
        applyStimulus(10'h000, 11'd2, 20);
        startExp(11'd2);
        exp_q.push_back('h12); exp_q.push_back('h34); exp_q.push_back('hAB); exp_q.push_back('hCD);
        checkBytes("basic");
        checkOutput("basic_rd_cyc", 32'(qget(rd_c, 0)), 32'(1 + HDR));
        checkOutput("basic_first_cyc", 32'(qget(wr_c, HDR)), 32'(3 + HDR));
        checkOutput("basic_last_cyc", 32'(qget(wr_c, HDR + 3)), 32'(8 + HDR));
        checkOutput("basic_ndone", 32'(done_c.size()), 32'd1);
        checkOutput("basic_done_cyc", 32'(qget(done_c, 0)), 32'(9 + HDR));
        checkOutput("basic_busy_send", 32'(qget(busy_h, 8 + HDR)), 32'd1);
        checkOutput("basic_busy_after", 32'(qget(busy_h, 10 + HDR)), 32'd0);

        // Address wrap from the top of the circular buffer.
        $display("[TB] wrap");
        applyStimulus(10'h3FF, 11'd2, 20);
        startExp(11'd2);
        exp_q.push_back('h0F); exp_q.push_back('h1E); exp_q.push_back('h12); exp_q.push_back('h34);
        checkBytes("wrap");
        checkOutput("wrap_addr0", 32'(qget(rd_a, 0)), 32'h3FF);
        checkOutput("wrap_addr1", 32'(qget(rd_a, 1)), 32'h000);
        checkOutput("wrap_rd1_cyc", 32'(qget(rd_c, 1)), 32'(5 + HDR));

        // FIFO full for five cycles after the first sample byte.
        $display("[TB] throttle");
        full_lo = 4 + HDR; full_hi = 8 + HDR;
        applyStimulus(10'h000, 11'd2, 24);
        startExp(11'd2);
        exp_q.push_back('h12); exp_q.push_back('h34); exp_q.push_back('hAB); exp_q.push_back('hCD);
        checkBytes("thr");
        checkOutput("thr_b0_cyc", 32'(qget(wr_c, HDR)), 32'(3 + HDR));
        checkOutput("thr_b1_cyc", 32'(qget(wr_c, HDR + 1)), 32'(9 + HDR));
        checkOutput("thr_done_cyc", 32'(qget(done_c, 0)), 32'(14 + HDR));

        // Processor write collides with the pending 0xAB.
        $display("[TB] collision");
        cpu_at = 7 + HDR; cpu_byte = 8'h55;
        applyStimulus(10'h000, 11'd2, 20);
        startExp(11'd2);
        exp_q.push_back('h12); exp_q.push_back('h34); exp_q.push_back('h55);
        exp_q.push_back('hAB); exp_q.push_back('hCD);
        checkBytes("col");
        checkOutput("col_cpu_cyc", 32'(qget(wr_c, HDR + 2)), 32'(7 + HDR));
        checkOutput("col_ab_cyc", 32'(qget(wr_c, HDR + 3)), 32'(8 + HDR));
        checkOutput("col_done_cyc", 32'(qget(done_c, 0)), 32'(10 + HDR));

        // Abort after three sample bytes (FIFO full holds the fourth).
        $display("[TB] abort");
        abort_at = 8 + HDR; full_lo = 8 + HDR; full_hi = 8 + HDR;
        applyStimulus(10'h000, 11'd3, 24);
        startExp(11'd3);
        exp_q.push_back('h12); exp_q.push_back('h34); exp_q.push_back('hAB);
        checkBytes("abort");
        checkOutput("abort_ndone", 32'(done_c.size()), 32'd0);
        checkOutput("abort_busy_before", 32'(qget(busy_h, 8 + HDR)), 32'd1);
        checkOutput("abort_busy_after", 32'(qget(busy_h, 9 + HDR)), 32'd0);
        checkOutput("abort_nrd", 32'(rd_a.size()), 32'd2);

        // Zero count.
        $display("[TB] zero count");
        applyStimulus(10'h000, 11'd0, 10);
        startExp(11'd0);
        checkBytes("zero");
        checkOutput("zero_nrd", 32'(rd_a.size()), 32'd0);
        checkOutput("zero_done_cyc", 32'(qget(done_c, 0)), 32'(1 + HDR));
        checkOutput("zero_ndone", 32'(done_c.size()), 32'd1);
        checkOutput("zero_busy", 32'(qget(busy_h, 1)), 32'(HDR != 0));

        // Start and abort in the same cycle: abort wins.
        $display("[TB] start with abort");
        abort_at = 0;
        applyStimulus(10'h000, 11'd2, 12);
        checkOutput("sa_nwr", 32'(wr_b.size()), 32'd0);
        checkOutput("sa_nrd", 32'(rd_a.size()), 32'd0);
        checkOutput("sa_ndone", 32'(done_c.size()), 32'd0);
        checkOutput("sa_busy", 32'(qget(busy_h, 1)), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
